// File: rtl/key_step_gen.sv
// Debounced push-button step generator: one single-cycle step per accepted press.
// Define KEY_AUTO_REPEAT_EN to add auto-repeat steps while the button stays held.
module key_step_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_ni,
  output logic       step_o,
  output logic       pressed_o,
  output logic [7:0] press_count_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StHeld        = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  logic            sync1_q, key_s_q;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            step_q, step_d;
  logic            pressed_q, pressed_d;
  logic [7:0]      press_count_q, press_count_d;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);
  localparam logic [RepW-1:0] RepOne        = RepW'(1);

  logic [RepW-1:0] rep_q, rep_d;
  logic            phase_q, phase_d; // 0: waiting first repeat, 1: periodic repeats
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_d        = 1'b0;
    pressed_d     = pressed_q;
    press_count_d = press_count_q + {7'd0, step_q};
`ifdef KEY_AUTO_REPEAT_EN
    rep_d         = rep_q;
    phase_d       = phase_q;
`endif
    case (state_q)
      StIdle: begin
        if (!key_s_q) begin
          state_d = StPressWait;
          cnt_d   = CntOne;
        end
      end
      StPressWait: begin
        if (key_s_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StHeld;
          step_d    = 1'b1;
          pressed_d = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
          rep_d     = '0;
          phase_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHeld: begin
        if (key_s_q) begin
          state_d = StReleaseWait;
          cnt_d   = CntOne;
        end
`ifdef KEY_AUTO_REPEAT_EN
        if (!phase_q && rep_q == RepDelayLast) begin
          step_d  = 1'b1;
          rep_d   = '0;
          phase_d = 1'b1;
        end else if (phase_q && rep_q == RepPeriodLast) begin
          step_d = 1'b1;
          rep_d  = '0;
        end else begin
          rep_d = rep_q + RepOne;
        end
`endif
      end
      StReleaseWait: begin
        if (!key_s_q) begin
          // Release bounce: back to held without a new step.
          state_d = StHeld;
`ifdef KEY_AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_q == CntMax) begin
          state_d   = StIdle;
          cnt_d     = '0;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q       <= 1'b1;
      key_s_q       <= 1'b1;
      state_q       <= StIdle;
      cnt_q         <= '0;
      step_q        <= 1'b0;
      pressed_q     <= 1'b0;
      press_count_q <= 8'd0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_q         <= '0;
      phase_q       <= 1'b0;
`endif
    end else begin
      sync1_q       <= key_ni;
      key_s_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      step_q        <= step_d;
      pressed_q     <= pressed_d;
      press_count_q <= press_count_d;
`ifdef KEY_AUTO_REPEAT_EN
      rep_q         <= rep_d;
      phase_q       <= phase_d;
`endif
    end
  end

  assign step_o        = step_q;
  assign pressed_o     = pressed_q;
  assign press_count_o = press_count_q;

endmodule

// File: tb/tb_key_step_gen.sv
// Directed bench for key_step_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_key_step_gen;

  localparam int unsigned Deb     = 4;
  localparam int unsigned RDelay  = 20;
  localparam int unsigned RPeriod = 8;
`ifdef KEY_AUTO_REPEAT_EN
  localparam int NRep = 5;
`else
  localparam int NRep = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic       step;
  logic       pressed;
  logic [7:0] press_count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_steps = 0;
  int unsigned n_consec = 0;
  logic        step_prev = 1'b0;

  key_step_gen #(
    .DEBOUNCE_CYCLES(Deb),
    .REPEAT_DELAY   (RDelay),
    .REPEAT_PERIOD  (RPeriod)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .key_ni       (key_n),
    .step_o       (step),
    .pressed_o    (pressed),
    .press_count_o(press_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step) n_steps <= n_steps + 1;
    if (step && step_prev) n_consec <= n_consec + 1;
    step_prev <= step;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Step must stay low for n-1 negedges and be high, with pressed, on the n-th.
  task automatic expect_step_at(input string tag, input int n);
    int early = 0;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      if (step) early++;
    end
    @(negedge clk);
    check({tag, " early step"}, early, 0);
    check({tag, " step"}, step, 1);
    check({tag, " pressed"}, pressed, 1);
  endtask

  task automatic press_release();
    key_n = 1'b0;
    tick(8);
    key_n = 1'b1;
    tick(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned early;
    int          q[$];
    int          exp_rep[5];
    exp_rep = '{20, 28, 36, 44, 52};

    // 1: clean press held through reset release
    rst_n = 1'b0;
    key_n = 1'b0;
    tick(3);
    check("reset step", step, 0);
    check("reset pressed", pressed, 0);
    check("reset count", press_count, 0);
    rst_n = 1'b1;
    expect_step_at("t1", 7);
    tick(1);
    check("t1 step clears", step, 0);
    check("t1 count", press_count, 1);
    key_n = 1'b1;
    tick(10);
    check("t1 released", pressed, 0);

    // 2: press bounce
    base = n_steps;
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(1);
    key_n = 1'b0;
    expect_step_at("t2", 7);
    tick(1);
    check("t2 pulses", n_steps - base, 1);

    // 3: release bounce
    base = n_steps;
    key_n = 1'b1; tick(3);
    key_n = 1'b0; tick(1);
    key_n = 1'b1;
    early = 0;
    for (int i = 1; i < 7; i++) begin
      @(negedge clk);
      if (!pressed) early++;
    end
    @(negedge clk);
    check("t3 early release", early, 0);
    check("t3 pressed falls", pressed, 0);
    tick(1);
    check("t3 extra steps", n_steps - base, 0);
    check("t3 count", press_count, 2);

    // 4: auto-repeat while held
    key_n = 1'b0;
    expect_step_at("t4", 7);
    for (int i = 1; i <= 56; i++) begin
      @(negedge clk);
      if (step) q.push_back(i);
      if (i == 56) key_n = 1'b1;
    end
    tick(12);
    check("t4 repeat count", q.size(), NRep);
    for (int k = 0; k < q.size() && k < NRep; k++) check("t4 repeat offset", q[k], exp_rep[k]);
    check("t4 count", press_count, 3 + NRep);
    check("t4 released", pressed, 0);

    // 6: reset in PRESS_WAIT with cnt=2, key held low
    key_n = 1'b0;
    tick(4);
    rst_n = 1'b0;
    early = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (step) early++;
    end
    check("t6 step in reset", early, 0);
    check("t6 pressed in reset", pressed, 0);
    check("t6 count in reset", press_count, 0);
    rst_n = 1'b1;
    expect_step_at("t6", 7);
    tick(1);
    check("t6 count", press_count, 1);
    key_n = 1'b1;
    tick(10);

    // 5: wrap, 256 presses in total counting the one above
    for (int p = 0; p < 254; p++) press_release();
    check("t5 count 255", press_count, 255);
    press_release();
    check("t5 count wraps", press_count, 0);

    check("no back-to-back step", n_consec, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
